// File: rtl/clock_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : clock_step_controller (with helper clock_step_debounce)
// Purpose  : Turns the prescaler's slow_clock (run mode) or a debounced step
//            button press (step mode) into a one-cycle cpu_tick enable in the
//            quick_clock domain. Mode switch and button are synchronized and
//            debounced locally.
// Config   : `define STEP_COUNTER_EN to implement the 8-bit tick_count
//            register; otherwise tick_count is tied to 8'h00.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Debouncer: the output follows the input only after the input has held a
// new level long enough. Counter is zero whenever input matches the output.
// ----------------------------------------------------------------------------
module clock_step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic level_o
);

  // Acceptance happens on the edge where the counter would reach
  // DEBOUNCE_CYCLES-1; 33-bit compare keeps the +1 from ever wrapping.
  localparam logic [32:0] c_ACCEPT_CNT = 33'(DEBOUNCE_CYCLES) - 33'd1;

  logic        level_q;
  logic        level_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [32:0] w_count_inc;

  assign w_count_inc = {1'b0, count_q} + 33'd1;

  // Next-state: count while the input disagrees, accept at the threshold.
  always_comb begin
    level_d = level_q;
    count_d = '0;
    if (level_i != level_q) begin
      if (w_count_inc >= c_ACCEPT_CNT) begin
        level_d = level_i;
      end else begin
        count_d = w_count_inc[31:0];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= RESET_LEVEL;
      count_q <= '0;
    end else begin
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  assign level_o = level_q;

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module clock_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       quick_clock,
  input  logic       n_reset,
  input  logic       slow_clock,
  input  logic       n_step_button,
  input  logic       run_mode,
  output logic       cpu_tick,
  output logic       mode_out,
  output logic [7:0] tick_count
);

  typedef enum logic [1:0] {
    STEP_IDLE = 2'd0,
    STEP_HELD = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Two-stage synchronizers: bit 0 is the first stage, bit 1 the second.
  logic [1:0] slow_sync_q;
  logic [1:0] btn_sync_q;
  logic [1:0] mode_sync_q;
  logic       slow_prev_q;

  logic       btn_deb;
  logic       mode_deb;
  logic       w_slow_rise;

  state_e     state_q;
  state_e     state_d;
  logic       cpu_tick_q;
  logic       tick_d;

  // Bring the asynchronous inputs into the quick_clock domain; the button
  // idles released (high) so its synchronizer resets to 1.
  always_ff @(posedge quick_clock or negedge n_reset) begin
    if (!n_reset) begin
      slow_sync_q <= 2'b00;
      btn_sync_q  <= 2'b11;
      mode_sync_q <= 2'b00;
      slow_prev_q <= 1'b0;
    end else begin
      slow_sync_q <= {slow_sync_q[0], slow_clock};
      btn_sync_q  <= {btn_sync_q[0], n_step_button};
      mode_sync_q <= {mode_sync_q[0], run_mode};
      slow_prev_q <= slow_sync_q[1];
    end
  end

  assign w_slow_rise = slow_sync_q[1] & ~slow_prev_q;

  clock_step_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1)
  ) u_btn_debounce (
    .clk     (quick_clock),
    .rst_n   (n_reset),
    .level_i (btn_sync_q[1]),
    .level_o (btn_deb)
  );

  clock_step_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b0)
  ) u_mode_debounce (
    .clk     (quick_clock),
    .rst_n   (n_reset),
    .level_i (mode_sync_q[1]),
    .level_o (mode_deb)
  );

  // Tick decision and next state. A mode change always wins: the cycle in
  // which the FSM switches between run and step never issues a tick.
  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    case (state_q)
      STEP_IDLE: begin
        if (mode_deb) begin
          state_d = RUN;
        end else if (!btn_deb) begin
          tick_d  = 1'b1;
          state_d = STEP_HELD;
        end
      end
      STEP_HELD: begin
        if (mode_deb) begin
          state_d = RUN;
        end else if (btn_deb) begin
          state_d = STEP_IDLE;
        end
      end
      RUN: begin
        if (!mode_deb) begin
          state_d = STEP_IDLE;
        end else if (w_slow_rise) begin
          tick_d = 1'b1;
        end
      end
      default: begin
        state_d = STEP_IDLE;
      end
    endcase
  end

  // FSM state and registered tick output; reset halts the CPU.
  always_ff @(posedge quick_clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= STEP_IDLE;
      cpu_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_tick_q <= tick_d;
    end
  end

  assign cpu_tick = cpu_tick_q;
  assign mode_out = mode_deb;

`ifdef STEP_COUNTER_EN
  logic [7:0] tick_count_q;

  // Count issued ticks on the same edge that raises cpu_tick; wraps at 256.
  always_ff @(posedge quick_clock or negedge n_reset) begin
    if (!n_reset) begin
      tick_count_q <= 8'h00;
    end else if (tick_d) begin
      tick_count_q <= tick_count_q + 8'd1;
    end
  end

  assign tick_count = tick_count_q;
`else
  assign tick_count = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_step_controller
// Purpose  : Scoreboard bench for clock_step_controller (DEBOUNCE_CYCLES = 4).
//            Stimulus pushes the expected tick (edge number, tick_count) into
//            a queue; a monitor pops and compares whenever cpu_tick is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_step_controller;

  logic       quick_clock   = 1'b0;
  logic       n_reset       = 1'b0;
  logic       slow_clock    = 1'b0;
  logic       n_step_button = 1'b1;
  logic       run_mode      = 1'b0;
  logic       cpu_tick;
  logic       mode_out;
  logic [7:0] tick_count;

  clock_step_controller #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .quick_clock   (quick_clock),
    .n_reset       (n_reset),
    .slow_clock    (slow_clock),
    .n_step_button (n_step_button),
    .run_mode      (run_mode),
    .cpu_tick      (cpu_tick),
    .mode_out      (mode_out),
    .tick_count    (tick_count)
  );

  always #5 quick_clock = ~quick_clock;

  // Edge counter: value equals the number of the most recent rising edge.
  int cyc = 0;
  always @(posedge quick_clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   issued   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [7:0] model_count();
`ifdef STEP_COUNTER_EN
    return issued[7:0];
`else
    return 8'h00;
`endif
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge quick_clock);
    #1;
  endtask

  task automatic expect_tick(input int at);
    exp_t e;
    issued++;
    e.at  = at;
    e.cnt = model_count();
    exp_q.push_back(e);
  endtask

  // One slow_clock rise in run mode: tick expected two edges after stage 1.
  task automatic slow_pulse(input int hi, input int lo);
    slow_clock = 1'b1;
    expect_tick(cyc + 3);
    wait_cyc(hi);
    slow_clock = 1'b0;
    wait_cyc(lo);
  endtask

  // Button press in step mode: tick at stage-1 edge + DEBOUNCE_CYCLES + 1.
  task automatic press(input int hold);
    n_step_button = 1'b0;
    expect_tick(cyc + 6);
    wait_cyc(hold);
    n_step_button = 1'b1;
    wait_cyc(10);
  endtask

  // Monitor: every cpu_tick must match the head of the scoreboard.
  always @(negedge quick_clock) begin
    if (cpu_tick === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_tick: cpu_tick high at edge %0d count %0h, required no tick",
                 cyc, tick_count);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.at == cyc && tick_count === mon_e.cnt) n_pass++;
        else $display("FAIL tick: edge %0d count %0h, required edge %0d count %0h",
                      cyc, tick_count, mon_e.at, mon_e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    wait_cyc(3);
    check8("reset_cpu_tick", {7'd0, cpu_tick}, 8'h00);
    check8("reset_mode_out", {7'd0, mode_out}, 8'h00);
    check8("reset_tick_count", tick_count, 8'h00);
    n_reset = 1'b1;

    // Idle in step mode with the button released: nothing happens.
    wait_cyc(5000);
    check8("idle_cpu_tick", {7'd0, cpu_tick}, 8'h00);
    check8("idle_mode_out", {7'd0, mode_out}, 8'h00);
    check8("idle_tick_count", tick_count, 8'h00);

    // Switch to run mode: debounced mode rises 5 edges after the drive.
    run_mode = 1'b1;
    wait_cyc(4);
    check8("mode_before_debounce", {7'd0, mode_out}, 8'h00);
    wait_cyc(1);
    check8("mode_after_debounce", {7'd0, mode_out}, 8'h01);
    wait_cyc(3);
    for (int i = 0; i < 3; i++) slow_pulse(10, 10);
    check8("run_count_3", tick_count, model_count());
    check8("run_pending", 8'(exp_q.size()), 8'h00);

    // Back to step mode.
    run_mode = 1'b0;
    wait_cyc(10);
    check8("step_mode_out", {7'd0, mode_out}, 8'h00);

    // Two-cycle glitch is rejected.
    n_step_button = 1'b0;
    wait_cyc(2);
    n_step_button = 1'b1;
    wait_cyc(12);

    // Two clean presses, one tick each despite a long hold.
    press(20);
    press(20);
    check8("step_count", tick_count, model_count());
    check8("step_pending", 8'(exp_q.size()), 8'h00);

    // Press and hold, then switch to run with a slow rise detected in the
    // very cycle the FSM changes mode: no tick for that rise.
    n_step_button = 1'b0;
    expect_tick(cyc + 6);
    wait_cyc(20);
    run_mode = 1'b1;
    wait_cyc(3);
    slow_clock = 1'b1;
    wait_cyc(2);
    slow_clock = 1'b0;
    wait_cyc(6);
    check8("switch_mode_out", {7'd0, mode_out}, 8'h01);
    check8("switch_pending", 8'(exp_q.size()), 8'h00);
    n_step_button = 1'b1;
    wait_cyc(2);
    slow_pulse(2, 4);

    // Run up to 255 ticks, then one more wraps tick_count to 0.
    while ((issued % 256) != 255) slow_pulse(2, 2);
    check8("count_255", tick_count, model_count());
    slow_pulse(2, 4);
    check8("count_wrap", tick_count, model_count());
    check8("wrap_pending", 8'(exp_q.size()), 8'h00);

    // Reset on the cycle before cpu_tick would rise: the tick is dropped.
    slow_clock = 1'b1;
    wait_cyc(2);
    n_reset    = 1'b0;
    slow_clock = 1'b0;
    issued     = 0;
    wait_cyc(3);
    check8("rst_mid_cpu_tick", {7'd0, cpu_tick}, 8'h00);
    check8("rst_mid_mode_out", {7'd0, mode_out}, 8'h00);
    check8("rst_mid_tick_count", tick_count, 8'h00);
    n_reset = 1'b1;
    wait_cyc(4);
    check8("rerelease_mode_low", {7'd0, mode_out}, 8'h00);
    wait_cyc(1);
    check8("rerelease_mode_high", {7'd0, mode_out}, 8'h01);
    wait_cyc(3);
    slow_pulse(2, 6);
    check8("after_reset_count", tick_count, model_count());

    wait_cyc(10);
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_tick: no tick seen, required tick at edge %0d count %0h",
               mon_e.at, mon_e.cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
